uart_alu_ctrl: RTL and testbench
================================

Name: uart_alu_ctrl

Overview:
Frame sequencer between the UART's RX/TX FIFOs and a combinational ALU.
- Pops three bytes from the RX FIFO: operand A, operand B, opcode.
- Drives the operands and opcode to the ALU and captures the result.
- Pushes one response byte into the TX FIFO.
- Sits at top level, wired directly to the UART rd_uart/r_data/rx_empty and wr_uart/w_data/tx_full ports.

Parameters:
DBIT, 8, data byte and operand width.
NB_OP, 6, opcode width; the low NB_OP bits of the opcode byte are used.
ERR_CODE, 8'hFF, byte sent for an invalid opcode.
TIMEOUT, 50000, clk cycles allowed between bytes of a frame (optional feature only).
TO_BITS, 16, timeout counter width; must satisfy 2^TO_BITS > TIMEOUT.

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-low
rx_empty  in  1  RX FIFO empty
r_data  in  DBIT  RX FIFO head word (first-word fall-through)
rd_uart  out  1  RX FIFO pop strobe
tx_full  in  1  TX FIFO full
w_data  out  DBIT  byte to TX FIFO
wr_uart  out  1  TX FIFO push strobe
o_data_a  out  DBIT  ALU operand A (registered)
o_data_b  out  DBIT  ALU operand B (registered)
o_op  out  NB_OP  ALU opcode (registered)
i_alu_result  in  DBIT  ALU result (combinational from o_data_a/o_data_b/o_op)
o_busy  out  1  high whenever state != GET_A
o_err  out  1  one-cycle pulse on invalid opcode or timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - state=GET_A.
  - o_data_a, o_data_b, o_op, w_data = 0.
  - rd_uart, wr_uart, o_busy, o_err = 0.
  - Timeout counter = 0.
- rd_uart = (state is GET_A, GET_B or GET_OP) & ~rx_empty. This is combinational.
- The byte on r_data is registered on the same edge rd_uart is high. One byte per cycle at most.
- GET_A: on pop, o_data_a<=r_data, go to GET_B.
- GET_B: on pop, o_data_b<=r_data, go to GET_OP.
- GET_OP: on pop, o_op<=r_data[NB_OP-1:0].
  - Valid opcode → EXEC.
  - Invalid opcode → SEND with w_data<=ERR_CODE, and o_err pulses on the next cycle.
- Valid opcodes:
  - 6'h20 ADD
  - 6'h22 SUB
  - 6'h24 AND
  - 6'h25 OR
  - 6'h26 XOR
  - 6'h27 NOR
  - 6'h03 SRA
  - 6'h02 SRL
  - All other opcodes are invalid, including any set bit in r_data[DBIT-1:NB_OP].
- EXEC: exactly one cycle. Operands are stable at the ALU. w_data<=i_alu_result, go to SEND. ALU path has one full cycle to settle.
- SEND:
  - wr_uart = ~tx_full. This is combinational, and w_data is held stable.
  - On the edge with wr_uart=1, go to GET_A.
  - While tx_full=1, wait indefinitely with wr_uart=0.
- Exactly one wr_uart pulse per frame. No rd_uart while in EXEC or SEND.
- RX bytes arriving during EXEC/SEND stay in the RX FIFO and are consumed by the next frame.
- o_data_a, o_data_b and o_op retain their values after SEND until overwritten by the next frame.
- Latency from the opcode pop edge to the wr_uart assertion (tx_full=0) is 2 cycles.
- Reset mid-frame: partial frame discarded; no wr_uart issued.
- Unreachable state encodings → GET_A.

Optional Feature:
Macro UART_ALU_CTRL_TIMEOUT_EN.
- Defined:
  - The counter clears on every pop and in GET_A.
  - In GET_B/GET_OP, the counter increments each cycle rx_empty=1.
  - On reaching TIMEOUT, the FSM returns to GET_A, discards the partial frame, pulses o_err for one cycle, and sends no TX byte.
- Undefined: no counter logic. GET_B/GET_OP wait forever.

Test Plan:
- RX bytes 0x05,0x03,0x20 back-to-back, tx_full=0 → o_data_a=0x05, o_data_b=0x03, o_op=0x20; a single wr_uart pulse with w_data=0x08 (ALU model = ADD); o_busy low afterward.
- Bytes 0x0F,0xF0,0x3F → a single wr_uart pulse with w_data=0xFF; o_err high for exactly 1 cycle; ALU result ignored.
- Frame 0x09,0x04,0x22 with tx_full=1 held for 20 cycles → wr_uart stays 0 and w_data=0x05 is held; one wr_uart pulse in the first cycle tx_full=0.
- Bytes spaced by 7 idle cycles (rx_empty=1) → rd_uart exactly 3 pulses, each in a cycle with rx_empty=0; result correct. Six queued bytes form two frames and produce two responses in order.
- reset asserted after operand B pop → all outputs 0 asynchronously; after release, frame 0x01,0x01,0x20 → w_data=0x02.
- With UART_ALU_CTRL_TIMEOUT_EN and TIMEOUT=100: send 0x11, then idle 100 cycles → o_err pulse, no wr_uart. Then frame 0x02,0x02,0x24 → w_data=0x02.

Source files
------------

// File: rtl/uart_alu_ctrl_if.sv
// UART FIFO-side bundle for the ALU frame sequencer.
// master: the sequencer (pops the RX FIFO, pushes the TX FIFO).
// slave:  the UART (or a model of it) that owns both FIFOs.
interface uart_alu_ctrl_if #(
    parameter int DBIT = 8
);
    logic            rx_empty;
    logic [DBIT-1:0] r_data;
    logic            rd_uart;
    logic            tx_full;
    logic [DBIT-1:0] w_data;
    logic            wr_uart;

    modport master (
        input  rx_empty,
        input  r_data,
        input  tx_full,
        output rd_uart,
        output w_data,
        output wr_uart
    );

    modport slave (
        output rx_empty,
        output r_data,
        output tx_full,
        input  rd_uart,
        input  w_data,
        input  wr_uart
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: frame sequencer between UART RX/TX FIFOs and a combinational ALU.
// A frame is three RX bytes (operand A, operand B, opcode); one response byte is
// pushed to the TX FIFO per frame: the ALU result, or ERR_CODE for a bad opcode.
// Optional inter-byte timeout is compiled in with `define UART_ALU_CTRL_TIMEOUT_EN.
// reset is asynchronous and active-low.
module uart_alu_ctrl #(
    parameter int              DBIT     = 8,
    parameter int              NB_OP    = 6,
    parameter logic [DBIT-1:0] ERR_CODE = 8'hFF,
    parameter int              TIMEOUT  = 50000,
    parameter int              TO_BITS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_alu_ctrl_if.master   uart,
    output logic [DBIT-1:0]   o_data_a,
    output logic [DBIT-1:0]   o_data_b,
    output logic [NB_OP-1:0]  o_op,
    input  logic [DBIT-1:0]   i_alu_result,
    output logic              o_busy,
    output logic              o_err
);

    localparam logic [NB_OP-1:0] OP_ADD = 6'h20;
    localparam logic [NB_OP-1:0] OP_SUB = 6'h22;
    localparam logic [NB_OP-1:0] OP_AND = 6'h24;
    localparam logic [NB_OP-1:0] OP_OR  = 6'h25;
    localparam logic [NB_OP-1:0] OP_XOR = 6'h26;
    localparam logic [NB_OP-1:0] OP_NOR = 6'h27;
    localparam logic [NB_OP-1:0] OP_SRA = 6'h03;
    localparam logic [NB_OP-1:0] OP_SRL = 6'h02;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            rd_pop;
    logic            tx_push;
    logic            op_bad;
    logic            timeout_hit;
    logic [DBIT-1:0] w_data_q;

    // An opcode byte is valid only if its upper bits are clear and the low
    // field names one of the eight supported ALU operations.
    function automatic logic op_is_valid(input logic [DBIT-1:0] op_byte);
        logic valid;
        valid = 1'b0;
        if (op_byte[DBIT-1:NB_OP] == '0) begin
            case (op_byte[NB_OP-1:0])
                OP_ADD, OP_SUB, OP_AND, OP_OR,
                OP_XOR, OP_NOR, OP_SRA, OP_SRL: valid = 1'b1;
                default:                        valid = 1'b0;
            endcase
        end
        return valid;
    endfunction

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

    logic [TO_BITS-1:0] to_cnt;
    logic               waiting;

    assign waiting     = (state == GET_B) || (state == GET_OP);
    assign timeout_hit = waiting && uart.rx_empty && (to_cnt == TO_LAST);

    // Count starved cycles inside a partial frame; any pop or leaving the wait states restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (!waiting || rd_pop || timeout_hit) begin
            to_cnt <= '0;
        end else if (uart.rx_empty) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    // Without the timeout a partial frame waits forever; keep the parameters referenced.
    logic [TO_BITS-1:0] unused_timeout;
    assign unused_timeout = TO_BITS'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= GET_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the combinational pop/push strobes.
    always_comb begin
        state_next = state;
        rd_pop     = 1'b0;
        tx_push    = 1'b0;
        op_bad     = 1'b0;
        case (state)
            GET_A: begin
                if (!uart.rx_empty) begin
                    rd_pop     = 1'b1;
                    state_next = GET_B;
                end
            end
            GET_B: begin
                if (!uart.rx_empty) begin
                    rd_pop     = 1'b1;
                    state_next = GET_OP;
                end else if (timeout_hit) begin
                    state_next = GET_A;
                end
            end
            GET_OP: begin
                if (!uart.rx_empty) begin
                    rd_pop = 1'b1;
                    if (op_is_valid(uart.r_data)) begin
                        state_next = EXEC;
                    end else begin
                        op_bad     = 1'b1;
                        state_next = SEND;
                    end
                end else if (timeout_hit) begin
                    state_next = GET_A;
                end
            end
            EXEC: begin
                state_next = SEND;
            end
            SEND: begin
                if (!uart.tx_full) begin
                    tx_push    = 1'b1;
                    state_next = GET_A;
                end
            end
            default: begin
                state_next = GET_A;
            end
        endcase
    end

    // Capture popped bytes, the ALU result or error code, and the error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_data_a <= '0;
            o_data_b <= '0;
            o_op     <= '0;
            w_data_q <= '0;
            o_err    <= 1'b0;
        end else begin
            o_err <= op_bad || timeout_hit;
            if (rd_pop) begin
                case (state)
                    GET_A:  o_data_a <= uart.r_data;
                    GET_B:  o_data_b <= uart.r_data;
                    GET_OP: begin
                        o_op <= uart.r_data[NB_OP-1:0];
                        if (op_bad) begin
                            w_data_q <= ERR_CODE;
                        end
                    end
                    default: ;
                endcase
            end
            if (state == EXEC) begin
                w_data_q <= i_alu_result;
            end
        end
    end

    assign uart.rd_uart = rd_pop;
    assign uart.wr_uart = tx_push;
    assign uart.w_data  = w_data_q;
    assign o_busy       = (state != GET_A);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Testbench for uart_alu_ctrl: FIFO models on both sides, a behavioural ALU,
// a directed vector table, hand-written multi-cycle sequences and random frames.
module tb_uart_alu_ctrl;

    localparam int TB_TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] o_data_a;
    logic [7:0] o_data_b;
    logic [5:0] o_op;
    logic [7:0] i_alu_result;
    logic       o_busy;
    logic       o_err;

    uart_alu_ctrl_if #(.DBIT(8)) uart ();

    uart_alu_ctrl #(
        .DBIT(8), .NB_OP(6), .ERR_CODE(8'hFF), .TIMEOUT(TB_TIMEOUT), .TO_BITS(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .uart(uart),
        .o_data_a(o_data_a),
        .o_data_b(o_data_b),
        .o_op(o_op),
        .i_alu_result(i_alu_result),
        .o_busy(o_busy),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int cycle = 0;
    int pop_count = 0;
    int bad_pop = 0;
    int err_count = 0;
    int last_pop_cycle = 0;
    int wr_cycle = 0;

    logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

    // Behavioural ALU, also used as the reference for expected results.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic [7:0] r;
        case (op)
            6'h20:   r = a + b;
            6'h22:   r = a - b;
            6'h24:   r = a & b;
            6'h25:   r = a | b;
            6'h26:   r = a ^ b;
            6'h27:   r = ~(a | b);
            6'h03:   r = $signed(a) >>> b;
            6'h02:   r = a >> b;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic bit ref_valid(input logic [7:0] op_byte);
        bit v;
        v = 1'b0;
        foreach (valid_ops[k]) begin
            if ({2'b00, valid_ops[k]} == op_byte) v = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [7:0] ref_response(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op_byte);
        return ref_valid(op_byte) ? alu_ref(a, b, op_byte[5:0]) : 8'hFF;
    endfunction

    always_comb i_alu_result = alu_ref(o_data_a, o_data_b, o_op);

    // UART-side model: strobes sampled at negedge, FIFOs updated at posedge.
    initial begin
        logic       pop_now;
        logic       wr_now;
        logic [7:0] wd_now;
        uart.rx_empty = 1'b1;
        uart.r_data   = 8'h00;
        uart.tx_full  = 1'b0;
        forever begin
            @(negedge clk);
            pop_now = uart.rd_uart;
            wr_now  = uart.wr_uart;
            wd_now  = uart.w_data;
            if (o_err) err_count++;
            if (pop_now && uart.rx_empty) bad_pop++;
            @(posedge clk);
            cycle++;
            if (reset) begin
                if (pop_now) begin
                    pop_count++;
                    last_pop_cycle = cycle;
                    if (rx_q.size() > 0) void'(rx_q.pop_front());
                end
                if (wr_now) begin
                    tx_q.push_back(wd_now);
                    wr_cycle = cycle;
                end
            end
            #1;
            uart.rx_empty = (rx_q.size() == 0);
            uart.r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        rx_q.push_back(a);
        rx_q.push_back(b);
        rx_q.push_back(op);
    endtask

    task automatic wait_responses(input int n, input int budget);
        for (int c = 0; c < budget && tx_q.size() < n; c++) @(negedge clk);
    endtask

    task automatic wait_pops(input int target, input int budget);
        for (int c = 0; c < budget && pop_count < target; c++) @(negedge clk);
    endtask

    task automatic clear_counts();
        tx_q.delete();
        err_count = 0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] res;
        bit         err;
    } vec_t;

    vec_t vecs [12];

    initial begin : main
        int p0;
        int err_seen_cycle;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rop;

        vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b0};
        vecs[1]  = '{8'h0F, 8'hF0, 8'h3F, 8'hFF, 1'b1};
        vecs[2]  = '{8'h03, 8'h05, 8'h22, 8'hFE, 1'b0};
        vecs[3]  = '{8'hFF, 8'h02, 8'h20, 8'h01, 1'b0};
        vecs[4]  = '{8'hCC, 8'hAA, 8'h24, 8'h88, 1'b0};
        vecs[5]  = '{8'hC0, 8'h0C, 8'h25, 8'hCC, 1'b0};
        vecs[6]  = '{8'hFF, 8'h0F, 8'h26, 8'hF0, 1'b0};
        vecs[7]  = '{8'h0F, 8'h30, 8'h27, 8'hC0, 1'b0};
        vecs[8]  = '{8'h80, 8'h02, 8'h03, 8'hE0, 1'b0};
        vecs[9]  = '{8'h80, 8'h02, 8'h02, 8'h20, 1'b0};
        vecs[10] = '{8'h12, 8'h34, 8'h60, 8'hFF, 1'b1};
        vecs[11] = '{8'h12, 8'h34, 8'h00, 8'hFF, 1'b1};

        // Reset state
        #12;
        checkOutput("rst_o_data_a", o_data_a, 0);
        checkOutput("rst_o_data_b", o_data_b, 0);
        checkOutput("rst_o_op", o_op, 0);
        checkOutput("rst_w_data", uart.w_data, 0);
        checkOutput("rst_wr_uart", uart.wr_uart, 0);
        checkOutput("rst_o_busy", o_busy, 0);
        checkOutput("rst_o_err", o_err, 0);
        @(posedge clk); #2; reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            clear_counts();
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op);
            wait_responses(1, 50);
            repeat (3) @(negedge clk);
            checkOutput($sformatf("vec%0d_resp_count", i), tx_q.size(), 1);
            checkOutput($sformatf("vec%0d_w_data", i), (tx_q.size() > 0) ? tx_q[0] : 8'hxx, vecs[i].res);
            checkOutput($sformatf("vec%0d_err_pulses", i), err_count, vecs[i].err ? 1 : 0);
            checkOutput($sformatf("vec%0d_o_data_a", i), o_data_a, vecs[i].a);
            checkOutput($sformatf("vec%0d_o_data_b", i), o_data_b, vecs[i].b);
            checkOutput($sformatf("vec%0d_o_op", i), o_op, vecs[i].op[5:0]);
            checkOutput($sformatf("vec%0d_o_busy", i), o_busy, 0);
            if (!vecs[i].err) checkOutput($sformatf("vec%0d_latency", i), wr_cycle - last_pop_cycle, 2);
        end

        // TX back-pressure: response held while tx_full
        clear_counts();
        @(posedge clk); #2; uart.tx_full = 1'b1;
        applyStimulus(8'h09, 8'h04, 8'h22);
        repeat (20) @(negedge clk);
        checkOutput("txfull_no_wr", tx_q.size(), 0);
        checkOutput("txfull_w_data_held", uart.w_data, 8'h05);
        checkOutput("txfull_busy", o_busy, 1);
        @(posedge clk); #2; uart.tx_full = 1'b0;
        @(posedge clk); #2;
        checkOutput("txfull_first_cycle_wr", tx_q.size(), 1);
        repeat (5) @(negedge clk);
        checkOutput("txfull_single_wr", tx_q.size(), 1);
        checkOutput("txfull_value", (tx_q.size() > 0) ? tx_q[0] : 8'hxx, 8'h05);

        // Bytes spaced by idle cycles
        clear_counts();
        p0 = pop_count;
        bad_pop = 0;
        rx_q.push_back(8'h21); wait_pops(p0 + 1, 20); repeat (7) @(negedge clk);
        rx_q.push_back(8'h13); wait_pops(p0 + 2, 20); repeat (7) @(negedge clk);
        rx_q.push_back(8'h26); wait_responses(1, 50);
        repeat (5) @(negedge clk);
        checkOutput("spaced_pops", pop_count - p0, 3);
        checkOutput("spaced_bad_pop", bad_pop, 0);
        checkOutput("spaced_result", (tx_q.size() > 0) ? tx_q[0] : 8'hxx, 8'h32);

        // Six queued bytes form two frames, answered in order
        clear_counts();
        applyStimulus(8'h10, 8'h20, 8'h20);
        applyStimulus(8'h50, 8'h30, 8'h22);
        wait_responses(2, 60);
        repeat (3) @(negedge clk);
        checkOutput("two_frames_count", tx_q.size(), 2);
        checkOutput("two_frames_first", (tx_q.size() > 0) ? tx_q[0] : 8'hxx, 8'h30);
        checkOutput("two_frames_second", (tx_q.size() > 1) ? tx_q[1] : 8'hxx, 8'h20);

        // Reset after operand B pop
        clear_counts();
        p0 = pop_count;
        rx_q.push_back(8'h33);
        rx_q.push_back(8'h44);
        wait_pops(p0 + 2, 20);
        @(posedge clk); #2; reset = 1'b0; #1;
        checkOutput("midrst_o_data_a", o_data_a, 0);
        checkOutput("midrst_o_data_b", o_data_b, 0);
        checkOutput("midrst_w_data", uart.w_data, 0);
        checkOutput("midrst_o_busy", o_busy, 0);
        checkOutput("midrst_o_err", o_err, 0);
        checkOutput("midrst_wr_uart", uart.wr_uart, 0);
        repeat (3) @(posedge clk);
        #2; reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midrst_no_wr", tx_q.size(), 0);
        applyStimulus(8'h01, 8'h01, 8'h20);
        wait_responses(1, 50);
        repeat (3) @(negedge clk);
        checkOutput("postrst_count", tx_q.size(), 1);
        checkOutput("postrst_value", (tx_q.size() > 0) ? tx_q[0] : 8'hxx, 8'h02);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
        // Inter-byte timeout abandons the partial frame
        clear_counts();
        p0 = pop_count;
        rx_q.push_back(8'h11);
        wait_pops(p0 + 1, 20);
        err_seen_cycle = -1;
        for (int c = 0; c < 130 && err_seen_cycle < 0; c++) begin
            @(negedge clk);
            if (err_count > 0) err_seen_cycle = cycle;
        end
        repeat (3) @(negedge clk);
        checkOutput("timeout_delay", err_seen_cycle - last_pop_cycle, TB_TIMEOUT);
        checkOutput("timeout_err_pulses", err_count, 1);
        checkOutput("timeout_no_wr", tx_q.size(), 0);
        checkOutput("timeout_idle", o_busy, 0);
        clear_counts();
        applyStimulus(8'h02, 8'h02, 8'h24);
        wait_responses(1, 50);
        repeat (3) @(negedge clk);
        checkOutput("after_timeout_value", (tx_q.size() > 0) ? tx_q[0] : 8'hxx, 8'h02);
`endif

        // Random frames against the reference model
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rop = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {2'b00, valid_ops[$urandom_range(0, 7)]};
            clear_counts();
            rx_q.push_back(ra);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rx_q.push_back(rb);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rx_q.push_back(rop);
            wait_responses(1, 60);
            repeat (3) @(negedge clk);
            checkOutput($sformatf("rand%0d_resp", i), (tx_q.size() == 1) ? tx_q[0] : 8'hxx,
                        ref_response(ra, rb, rop));
            checkOutput($sformatf("rand%0d_err", i), err_count, ref_valid(rop) ? 0 : 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
